// File: rtl/sipo_word_receiver.sv
// MSB-first serial-to-parallel word receiver.
// A valid/ack holding register presents each word and flags overruns.
module sipo_word_receiver #(
  parameter int WIDTH = 4,
  parameter int CW    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sin,
  input  logic             bit_en,
  input  logic             data_ack,
  input  logic             clear_ovr,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             busy,
  output logic [CW-1:0]    bit_cnt,
  output logic             overrun
);

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dv_q, dv_d;
  logic             ovr_q, ovr_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] shifted;

  assign shifted = {shreg_q[WIDTH-2:0], sin};

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    dout_d  = dout_q;
    cnt_d   = cnt_q;
    dv_d    = dv_q;
    ovr_d   = ovr_q;
    if (dv_q && data_ack) dv_d = 1'b0;
    if (clear_ovr) ovr_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && bit_en) begin
          shreg_d = shifted;
          cnt_d   = CW'(1);
          state_d = RECV;
        end
      end
      RECV: begin
        if (bit_en) begin
          if (start) begin
            shreg_d = shifted;
            cnt_d   = CW'(1);
          end else if (cnt_q == LAST) begin
            dout_d  = shifted;
            dv_d    = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
            // set beats clear when the old word was never taken
            if (dv_q && !data_ack) ovr_d = 1'b1;
          end else begin
            shreg_d = shifted;
            cnt_d   = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RECV);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      dout_q  <= '0;
      cnt_q   <= '0;
      dv_q    <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      dout_q  <= dout_d;
      cnt_q   <= cnt_d;
      dv_q    <= dv_d;
      ovr_q   <= ovr_d;
      busy_q  <= busy_d;
    end
  end

  assign data_out   = dout_q;
  assign data_valid = dv_q;
  assign busy       = busy_q;
  assign bit_cnt    = cnt_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_sipo_word_receiver.sv
// Directed bench for sipo_word_receiver (WIDTH=4).
// Expected words are queued as frames are driven and popped on completion.
module tb_sipo_word_receiver;

  logic       clk = 1'b0;
  logic       reset, start, sin, bit_en, data_ack, clear_ovr;
  logic [3:0] data_out;
  logic       data_valid, busy, overrun;
  logic [4:0] bit_cnt;

  int n_cmp = 0;
  int n_mis = 0;
  logic [3:0] exp_q[$];

  sipo_word_receiver #(.WIDTH(4), .CW(5)) dut (
    .clk(clk), .reset(reset), .start(start), .sin(sin),
    .bit_en(bit_en), .data_ack(data_ack), .clear_ovr(clear_ovr),
    .data_out(data_out), .data_valid(data_valid), .busy(busy),
    .bit_cnt(bit_cnt), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic st, input logic s, input logic en,
                      input logic ack, input logic clr);
    start = st; sin = s; bit_en = en;
    data_ack = ack; clear_ovr = clr;
    @(posedge clk); #1;
    start = 0; sin = 0; bit_en = 0;
    data_ack = 0; clear_ovr = 0;
  endtask

  task automatic pop_chk(input string tag);
    logic [3:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_q_empty"}, 1, 0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_dout"}, data_out, e);
    end
  endtask

  task automatic frame(input string tag, input logic [3:0] w,
                       input logic ack_last, input logic clr_last);
    exp_q.push_back(w);
    for (int i = 3; i >= 1; i--) step(i == 3, w[i], 1, 0, 0);
    step(0, w[0], 1, ack_last, clr_last);
    chk({tag, "_dv"}, data_valid, 1);
    pop_chk(tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_cnt"}, bit_cnt, 0);
  endtask

  initial begin
    reset = 1; start = 0; sin = 0; bit_en = 0;
    data_ack = 0; clear_ovr = 0;
    @(posedge clk); @(posedge clk); #1;
    reset = 0;
    chk("rst_dout", data_out, 0);
    chk("rst_dv", data_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", bit_cnt, 0);
    chk("rst_ovr", overrun, 0);

    // stray bits and start without bit_en are ignored
    step(0, 1, 1, 0, 0);
    chk("stray_cnt", bit_cnt, 0);
    chk("stray_busy", busy, 0);
    step(1, 1, 0, 0, 0);
    chk("nostart_busy", busy, 0);

    // basic frame
    step(1, 1, 1, 0, 0);
    chk("basic_busy1", busy, 1);
    chk("basic_cnt1", bit_cnt, 1);
    step(0, 0, 1, 0, 0);
    step(0, 1, 1, 0, 0);
    chk("basic_dv_early", data_valid, 0);
    exp_q.push_back(4'hA);
    step(0, 0, 1, 0, 0);
    chk("basic_dv", data_valid, 1);
    pop_chk("basic");
    chk("basic_busy", busy, 0);
    chk("basic_cnt", bit_cnt, 0);
    step(0, 0, 0, 1, 0);
    chk("basic_ack", data_valid, 0);
    step(0, 0, 0, 1, 0);
    chk("ack_idle", data_valid, 0);

    // gapped bits
    exp_q.push_back(4'hF);
    for (int i = 3; i >= 0; i--) begin
      step(i == 3, 1, 1, 0, 0);
      chk("gap_cnt", bit_cnt, (i == 0) ? 0 : 4 - i);
      chk("gap_dv", data_valid, i == 0);
      if (i != 0) begin
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("gap_hold", bit_cnt, 4 - i);
        chk("gap_busy", busy, 1);
      end
    end
    pop_chk("gap");
    step(0, 0, 0, 1, 0);

    // overrun
    frame("ovr_a", 4'h5, 0, 0);
    chk("ovr_a_flag", overrun, 0);
    frame("ovr_b", 4'hC, 0, 0);
    chk("ovr_b_flag", overrun, 1);
    step(0, 0, 0, 0, 1);
    chk("ovr_clr", overrun, 0);
    chk("ovr_clr_dv", data_valid, 1);

    // completion with ack in the same cycle
    frame("ackc", 4'h3, 1, 0);
    chk("ackc_ovr", overrun, 0);
    step(0, 0, 0, 1, 0);
    chk("ackc_done", data_valid, 0);

    // restart mid-frame
    step(1, 1, 1, 0, 0);
    step(0, 1, 1, 0, 0);
    step(1, 0, 1, 0, 0);
    chk("rs_cnt", bit_cnt, 1);
    chk("rs_busy", busy, 1);
    step(0, 1, 1, 0, 0);
    step(0, 1, 1, 0, 0);
    chk("rs_dv_early", data_valid, 0);
    exp_q.push_back(4'h6);
    step(0, 0, 1, 0, 0);
    chk("rs_dv", data_valid, 1);
    pop_chk("rs");

    // back-to-back frame right after completion; set beats clear
    frame("b2b", 4'h2, 0, 1);
    chk("b2b_ovr", overrun, 1);

    // reset mid-frame drops partial and pending word
    step(1, 0, 1, 0, 0);
    step(0, 1, 1, 0, 0);
    step(0, 1, 1, 0, 0);
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    chk("mrst_dout", data_out, 0);
    chk("mrst_dv", data_valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_cnt", bit_cnt, 0);
    chk("mrst_ovr", overrun, 0);
    frame("post", 4'h9, 0, 0);
    chk("post_ovr", overrun, 0);

    chk("queue_left", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/sipo_word_receiver.md
Name: sipo_word_receiver

Overview:
- Receive-side counterpart of the team's 4-bit parallel-load / shift-left transmitter register. That register loads a word, then shifts it out MSB-first on its top bit.
- This block deserializes that MSB-first serial stream back into WIDTH-bit words.
- Each completed word is presented on a holding register with a valid/ack handshake.
- It sits at the far end of the serial link and feeds the parallel consumer logic.

Parameters:
- WIDTH, 4, bits per word. Legal range 2..16.
- CW, 5, width of the bit_cnt output. Must satisfy 2^CW > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  frame-start marker; the first (MSB) bit is on sin in the same cycle.
- sin  input  1  serial data, MSB first.
- bit_en  input  1  sin is valid this cycle; no bit is taken when low.
- data_ack  input  1  consumer accepts data_out.
- clear_ovr  input  1  clears the sticky overrun flag.
- data_out  output  WIDTH  last completed word (registered).
- data_valid  output  1  data_out holds an unacknowledged word.
- busy  output  1  a frame is in progress (state RECV).
- bit_cnt  output  CW  bits received in the current frame.
- overrun  output  1  sticky: a word completed while the previous word was still unacknowledged.

Behaviour:
- All state changes on the rising clk edge. reset has priority over every other input.
- Reset values: data_out=0, data_valid=0, busy=0, bit_cnt=0, overrun=0, shift register=0, state=IDLE.
- Reset mid-frame discards the partial word. Reset while data_valid=1 drops the pending word.
- FSM state IDLE:
  - start=1 and bit_en=1: shreg <= {shreg[WIDTH-2:0], sin}, bit_cnt <= 1, go to RECV.
  - start=1 with bit_en=0: ignored.
  - bit_en=1 without start: ignored; stray bits are not counted.
- FSM state RECV:
  - bit_en=1 and bit_cnt < WIDTH-1: shift sin in at the LSB; bit_cnt increments.
  - bit_en=1 and bit_cnt == WIDTH-1 (completion): data_out <= {shreg[WIDTH-2:0], sin}, data_valid <= 1, bit_cnt <= 0, go to IDLE.
  - bit_en=0: hold all state. Gaps of any length are legal.
  - start=1 and bit_en=1 in RECV (restart): discard the partial word and treat sin as a new MSB (bit_cnt <= 1, stay in RECV). Restart takes priority over completion in the same cycle.
  - start=1 with bit_en=0 in RECV: ignored.
- Latency: data_valid rises on the same edge that samples the last bit; data_out is valid in that cycle.
- Back-to-back frames: a new start may coincide with the cycle after completion. There are no dead cycles.
- Handshake:
  - data_valid stays high until a cycle with data_ack=1. The edge at the end of that cycle clears it.
  - data_ack while data_valid=0: ignored.
  - Completion with data_ack=1 in the same cycle: the new word loads, data_valid stays 1, overrun is unchanged.
  - Completion while data_valid=1 and data_ack=0: the new word overwrites data_out (newest wins), data_valid stays 1, overrun <= 1.
- Overrun flag:
  - overrun holds until clear_ovr=1 or reset.
  - If clear_ovr and a new overrun event occur in the same cycle, overrun stays 1 (set wins).
- busy = (state == RECV), registered. bit_cnt never exceeds WIDTH-1.

Test Plan (WIDTH=4):
- Basic frame. After reset, drive start=1,bit_en=1,sin=1, then bit_en=1 with sin=0,1,0 on three consecutive cycles. Expect data_valid=1 and data_out=4'hA after the 4th edge, busy=0, bit_cnt=0. Then data_ack=1 for one cycle; expect data_valid=0.
- Gapped bits. Send 4'hF with bit_en low for 2 cycles between each bit. Expect no data_valid until the 4th enabled bit, data_out=4'hF, and bit_cnt stepping 1,2,3 then 0.
- Overrun. Send 4'h5 without ack, then send 4'hC. Expect data_out=4'hC, data_valid=1, overrun=1. Pulse clear_ovr; expect overrun=0 and data_valid still 1.
- Completion with ack in the same cycle. Hold data_ack=1 on the completing cycle of a second frame; expect the new word, data_valid=1, overrun=0.
- Restart. After 2 bits (1,1), assert start with sin=0, then sin=1,1,0. Expect data_out=4'h6; the partial bits are discarded.
- Reset mid-frame. Assert reset after 3 bits of a frame. Expect all outputs 0. Next, a full frame 4'h9 received correctly.
